// File: rtl/mips_trace_buffer.sv
// Circular trace buffer for a MIPS core: captures PC/instruction/store samples
// around a PC or store-address trigger, then plays them back oldest-first.
module mips_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int POST  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     trig_pc_en,
    input  logic [31:0]              trig_pc,
    input  logic                     trig_addr_en,
    input  logic [31:0]              trig_addr,
    input  logic                     tr_valid,
    input  logic [31:0]              pc,
    input  logic [31:0]              instr,
    input  logic                     mem_we,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wd,
    output logic                     armed,
    output logic                     triggered,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [31:0]              rd_pc,
    output logic [31:0]              rd_instr,
    output logic                     rd_mem_we,
    output logic [31:0]              rd_mem_addr,
    output logic [31:0]              rd_mem_wd,
    output logic                     rd_last
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW-1:0]   post_cnt;
    logic [FW-1:0]   fill_inc;
    logic [FW-1:0]   rd_start;
    logic            capture, hit, pop, post_last, enter_done;

    logic [31:0]     mem_pc    [DEPTH];
    logic [31:0]     mem_instr [DEPTH];
    logic            mem_wen   [DEPTH];
    logic [31:0]     mem_waddr [DEPTH];
    logic [31:0]     mem_wdata [DEPTH];

    always_comb begin
        capture    = tr_valid && (state == S_ARMED || state == S_POST);
        hit        = tr_valid && ((trig_pc_en && pc == trig_pc) ||
                                  (trig_addr_en && mem_we && mem_addr == trig_addr));
        pop        = rd_valid && rd_ready;
        post_last  = (post_cnt == AW'(POST - 1));
        enter_done = capture && (state == S_POST) && post_last;
        fill_inc   = (fill == FW'(DEPTH)) ? fill : fill + 1'b1;
        // Oldest entry sits fill_inc slots behind the slot after the one being written.
        rd_start   = {1'b0, wr_ptr} + 1'b1 - fill_inc;

        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_ARMED: if (capture && hit) state_nxt = S_POST;
            S_POST:  if (enter_done) state_nxt = S_DONE;
            S_DONE:  if (pop && fill == FW'(1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (arm) state_nxt = S_ARMED;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || arm) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            post_cnt <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
                fill   <= fill_inc;
                if (state == S_POST) post_cnt <= post_cnt + 1'b1;
            end
            if (enter_done) rd_ptr <= rd_start[AW-1:0];
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                fill   <= fill - 1'b1;
            end
        end
    end

    // Storage carries no reset; an arm cycle drops its in-flight sample.
    always_ff @(posedge clk) begin
        if (capture && !arm) begin
            mem_pc[wr_ptr]    <= pc;
            mem_instr[wr_ptr] <= instr;
            mem_wen[wr_ptr]   <= mem_we;
            mem_waddr[wr_ptr] <= mem_addr;
            mem_wdata[wr_ptr] <= mem_wd;
        end
    end

    assign armed       = (state == S_ARMED) || (state == S_POST);
    assign triggered   = (state == S_POST) || (state == S_DONE);
    assign done        = (state == S_DONE);
    assign rd_valid    = (state == S_DONE) && (fill != '0);
    assign rd_last     = rd_valid && (fill == FW'(1));
    assign rd_pc       = mem_pc[rd_ptr];
    assign rd_instr    = mem_instr[rd_ptr];
    assign rd_mem_we   = mem_wen[rd_ptr];
    assign rd_mem_addr = mem_waddr[rd_ptr];
    assign rd_mem_wd   = mem_wdata[rd_ptr];

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Bench for mips_trace_buffer: queue-based reference model checked every cycle,
// directed trigger/wrap/backpressure/arm/reset scenarios, then random traffic.
module tb_mips_trace_buffer;

    localparam int DEPTH = 16;
    localparam int POST  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, arm, trig_pc_en, trig_addr_en, tr_valid, mem_we, rd_ready;
    logic [31:0] trig_pc, trig_addr, pc, instr, mem_addr, mem_wd;
    logic        armed, triggered, done, rd_valid, rd_last, rd_mem_we;
    logic [$clog2(DEPTH):0] fill;
    logic [31:0] rd_pc, rd_instr, rd_mem_addr, rd_mem_wd;

    mips_trace_buffer #(.DEPTH(DEPTH), .POST(POST)) dut (
        .clk(clk), .rst(rst), .arm(arm),
        .trig_pc_en(trig_pc_en), .trig_pc(trig_pc),
        .trig_addr_en(trig_addr_en), .trig_addr(trig_addr),
        .tr_valid(tr_valid), .pc(pc), .instr(instr),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .armed(armed), .triggered(triggered), .done(done), .fill(fill),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_mem_we(rd_mem_we),
        .rd_mem_addr(rd_mem_addr), .rd_mem_wd(rd_mem_wd), .rd_last(rd_last)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
    } ent_t;

    // Model: 0 idle, 1 armed, 2 post-trigger, 3 done; q holds entries oldest-first.
    ent_t q[$];
    int   mode = 0;
    int   post_seen = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   chk_en = 1'b0;

    task automatic chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit   hit;
        ent_t e;
        hit = tr_valid && ((trig_pc_en && pc == trig_pc) ||
                           (trig_addr_en && mem_we && mem_addr == trig_addr));
        if (rst) begin
            mode = 0; q.delete(); post_seen = 0;
        end else if (arm) begin
            mode = 1; q.delete(); post_seen = 0;
        end else if ((mode == 1 || mode == 2) && tr_valid) begin
            e.pc = pc; e.instr = instr; e.we = mem_we; e.addr = mem_addr; e.wd = mem_wd;
            q.push_back(e);
            if (q.size() > DEPTH) void'(q.pop_front());
            if (mode == 2) begin
                post_seen++;
                if (post_seen == POST) mode = 3;
            end else if (hit) begin
                mode = 2;
            end
        end else if (mode == 3 && rd_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) mode = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic sample(input logic [31:0] p, input logic we, input logic [31:0] a);
        tr_valid = 1'b1;
        pc = p;
        instr = 32'h2400_0000 | p;
        mem_we = we;
        mem_addr = a;
        mem_wd = ~p;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("armed", armed, (mode == 1 || mode == 2));
            chk("triggered", triggered, (mode == 2 || mode == 3));
            chk("done", done, (mode == 3));
            chk("fill", fill, q.size());
            chk("rd_valid", rd_valid, (mode == 3 && q.size() > 0));
            chk("rd_last", rd_last, (mode == 3 && q.size() == 1));
            if (mode == 3 && q.size() > 0) begin
                chk("rd_pc", rd_pc, q[0].pc);
                chk("rd_instr", rd_instr, q[0].instr);
                chk("rd_mem_we", rd_mem_we, q[0].we);
                chk("rd_mem_addr", rd_mem_addr, q[0].addr);
                chk("rd_mem_wd", rd_mem_wd, q[0].wd);
            end
        end
    end

    initial begin
        logic [31:0] got[$];
        int idx;
        rst = 1'b1; arm = 1'b0; trig_pc_en = 1'b0; trig_addr_en = 1'b0;
        trig_pc = '0; trig_addr = '0; tr_valid = 1'b0; pc = '0; instr = '0;
        mem_we = 1'b0; mem_addr = '0; mem_wd = '0; rd_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_armed", armed, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_done", done, 0);
        chk("rst_fill", fill, 0);
        chk("rst_rd_valid", rd_valid, 0);

        // PC trigger at 0x08: two post samples leave it in POST with five entries.
        trig_pc_en = 1'b1; trig_pc = 32'h08;
        arm = 1'b1; tick(); arm = 1'b0;
        chk("arm_armed", armed, 1);
        for (int i = 0; i < 5; i++) begin sample(4 * i, 1'b0, 0); tick(); end
        tr_valid = 1'b0;
        chk("pc5_triggered", triggered, 1);
        chk("pc5_done", done, 0);
        chk("pc5_fill", fill, 5);
        for (int i = 5; i < 11; i++) begin sample(4 * i, 1'b0, 0); tick(); end
        tr_valid = 1'b0;
        chk("pc11_done", done, 1);
        chk("pc11_fill", fill, 11);
        rd_ready = 1'b1;
        idx = 0;
        for (int k = 0; k < 20 && rd_valid; k++) begin
            chk("seq_pc", rd_pc, 4 * idx);
            if (idx == 10) chk("seq_last", rd_last, 1);
            tick();
            idx++;
        end
        rd_ready = 1'b0;
        chk("seq_count", idx, 11);
        chk("seq_idle_armed", armed, 0);

        // Wrap: trigger at i=25, DONE after i=33, oldest retained is i=18.
        trig_pc = 32'd100;
        arm = 1'b1; tick(); arm = 1'b0;
        for (int i = 0; i < 34; i++) begin sample(4 * i, 1'b0, 0); tick(); end
        tr_valid = 1'b0;
        chk("wrap_done", done, 1);
        chk("wrap_fill", fill, 16);
        chk("wrap_oldest", rd_pc, 72);
        // Backpressure: rd_ready alternates 1,0,1,0...
        for (int c = 0; c < 100 && rd_valid; c++) begin
            rd_ready = (c % 2 == 0);
            if (rd_valid && rd_ready) got.push_back(rd_pc);
            tick();
        end
        rd_ready = 1'b0;
        chk("bp_count", got.size(), 16);
        for (int i = 0; i < got.size() && i < 16; i++) chk("bp_pc", got[i], 4 * (18 + i));
        chk("bp_idle_done", done, 0);

        // Store-address trigger needs mem_we.
        trig_pc_en = 1'b0; trig_addr_en = 1'b1; trig_addr = 32'h40;
        arm = 1'b1; tick(); arm = 1'b0;
        sample(32'h200, 1'b0, 32'h40); tick();
        chk("st_nowe_trig", triggered, 0);
        sample(32'h204, 1'b1, 32'h40); tick();
        chk("st_we_trig", triggered, 1);
        for (int i = 0; i < POST; i++) begin sample(32'h208 + 4 * i, 1'b0, 0); tick(); end
        tr_valid = 1'b0;
        chk("st_done", done, 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        arm = 1'b1; tick(); arm = 1'b0; rd_ready = 1'b0;
        chk("rearm_armed", armed, 1);
        chk("rearm_fill", fill, 0);
        chk("rearm_rd_valid", rd_valid, 0);
        sample(32'h300, 1'b1, 32'h40); tick();
        sample(32'h304, 1'b0, 0); tick();
        tr_valid = 1'b0;
        chk("post_triggered", triggered, 1);
        rst = 1'b1; arm = 1'b1; tick(); rst = 1'b0; arm = 1'b0;
        chk("rst_post_armed", armed, 0);
        chk("rst_post_triggered", triggered, 0);
        chk("rst_post_done", done, 0);
        chk("rst_post_fill", fill, 0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            arm = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 99) == 0) begin
                trig_pc_en = $urandom_range(0, 1);
                trig_addr_en = $urandom_range(0, 1);
                trig_pc = $urandom_range(0, 15) * 4;
                trig_addr = $urandom_range(0, 7) * 4;
            end
            tr_valid = ($urandom_range(0, 3) != 0);
            pc = $urandom_range(0, 15) * 4;
            instr = $urandom;
            mem_we = $urandom_range(0, 1);
            mem_addr = $urandom_range(0, 7) * 4;
            mem_wd = $urandom;
            rd_ready = $urandom_range(0, 1);
            tick();
        end
        rst = 1'b0; arm = 1'b0; tr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
